// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the TDM link: frame-alignment states and channel geometry.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned NCH    = 4;
  localparam int unsigned SLOT_W = 2;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out bundle of the 4-channel TDM demultiplexer.
interface tdm_demux4_if #(
  parameter int unsigned W = 1
);

  logic [W-1:0]                 din;
  logic                         din_valid;
  logic                         din_sync;
  logic [tdm_pkg::NCH*W-1:0]    dout;
  logic                         dout_valid;
  logic [tdm_pkg::SLOT_W-1:0]   slot;
  logic                         locked;
  logic                         sync_err;

  modport master (
    output din, din_valid, din_sync,
    input  dout, dout_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, din_sync,
    output dout, dout_valid, slot, locked, sync_err
  );

endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit TDM slot counter; priority clear > load-to-1 > advance, wraps 3 -> 0.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              load1,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot,
  output logic              wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clear) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (advance) begin
      slot <= slot + SLOT_W'(1);
    end
  end

  assign wrap = (slot == '1);

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side TDM demux: aligns to din_sync and emits all four lanes as one registered word.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  state_t              state, state_n;
  logic [3*W-1:0]      shadow, shadow_n;
  logic [NCH*W-1:0]    dout_r, dout_n;
  logic                dv_r, dv_n;
  logic                se_r, se_n;
  logic                adv, ld1, clr;
  logic [SLOT_W-1:0]   slot;
  logic                wrap;

  tdm_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (adv),
    .load1   (ld1),
    .clear   (clr),
    .slot    (slot),
    .wrap    (wrap)
  );

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    dout_n   = dout_r;
    dv_n     = 1'b0;
    se_n     = 1'b0;
    adv      = 1'b0;
    ld1      = 1'b0;
    clr      = 1'b0;
    if (bus.din_valid) begin
      unique case (state)
        HUNT: begin
          if (bus.din_sync) begin
            shadow_n[0 +: W] = bus.din;
            ld1              = 1'b1;
            state_n          = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == '0) begin
            if (bus.din_sync) begin
              shadow_n[0 +: W] = bus.din;
              ld1              = 1'b1;
            end else begin
              se_n    = 1'b1;
              clr     = 1'b1;
              state_n = HUNT;
            end
          end else if (bus.din_sync) begin
            // Early sync restarts the frame here; stale upper lanes get overwritten before use.
            se_n             = 1'b1;
            shadow_n[0 +: W] = bus.din;
            ld1              = 1'b1;
          end else if (wrap) begin
            dout_n = {bus.din, shadow};
            dv_n   = 1'b1;
            adv    = 1'b1;
          end else begin
            case (slot)
              SLOT_W'(1): shadow_n[W +: W]   = bus.din;
              SLOT_W'(2): shadow_n[2*W +: W] = bus.din;
              default:    ;
            endcase
            adv = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      shadow <= '0;
      dout_r <= '0;
      dv_r   <= 1'b0;
      se_r   <= 1'b0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      dout_r <= dout_n;
      dv_r   <= dv_n;
      se_r   <= se_n;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dv_r;
  assign bus.slot       = slot;
  assign bus.locked     = (state == LOCKED);
  assign bus.sync_err   = se_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (W=1): directed scenarios plus random stream vs. frame-level model.
module tb_tdm_demux4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux4_if #(.W(1)) bus ();

  tdm_demux4 #(.W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Frame-level reference: aligned flag, index of next lane, collected lanes, last frame.
  bit       m_aligned;
  int       m_next;
  bit [3:0] m_lanes;
  bit [3:0] m_frame;
  bit       m_dv;
  bit       m_se;
  int       last_dv_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_aligned = 0;
    m_next    = 0;
    m_lanes   = '0;
    m_frame   = '0;
    m_dv      = 0;
    m_se      = 0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit s);
    m_dv = 0;
    m_se = 0;
    if (!v) return;
    if (s) begin
      if (m_aligned && m_next != 0) m_se = 1;
      m_aligned  = 1;
      m_lanes    = '0;
      m_lanes[0] = d;
      m_next     = 1;
    end else if (!m_aligned) begin
      // sample dropped while hunting
    end else if (m_next == 0) begin
      m_se      = 1;
      m_aligned = 0;
    end else begin
      m_lanes[m_next] = d;
      if (m_next == 3) begin
        m_frame = m_lanes;
        m_dv    = 1;
        m_next  = 0;
      end else begin
        m_next = m_next + 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("dout",       32'(bus.dout),       32'(m_frame));
    chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    chk("slot",       32'(bus.slot),       32'(m_next));
    chk("locked",     32'(bus.locked),     32'(m_aligned));
    chk("sync_err",   32'(bus.sync_err),   32'(m_se));
  endtask

  task automatic step(input bit d, input bit v, input bit s);
    @(negedge clk);
    bus.din       = d;
    bus.din_valid = v;
    bus.din_sync  = s;
    @(posedge clk);
    #1;
    cyc++;
    model_step(d, v, s);
    if (bus.dout_valid === 1'b1) last_dv_cyc = cyc;
    compare_all();
  endtask

  task automatic frame(input bit [3:0] lanes);
    step(lanes[0], 1, 1);
    step(lanes[1], 1, 0);
    step(lanes[2], 1, 0);
    step(lanes[3], 1, 0);
  endtask

  initial begin
    int c1;
    bit v, s, d;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.din_sync  = 1'b0;
    model_reset();
    last_dv_cyc = 0;

    #12;
    compare_all();
    chk("reset_dout_const", 32'(bus.dout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsynced samples are ignored while hunting
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("hunt_locked", 32'(bus.locked), 32'h0);
    chk("hunt_dout",   32'(bus.dout),   32'h0);

    // First aligned frame 1,0,1,1
    step(1, 1, 1);
    chk("lock_rise", 32'(bus.locked), 32'h1);
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("frame1_dout", 32'(bus.dout),       32'hd);
    chk("frame1_dv",   32'(bus.dout_valid), 32'h1);
    chk("frame1_slot", 32'(bus.slot),       32'h0);

    // Back-to-back frames 0001 then 0110
    frame(4'b0001);
    chk("b2b_first", 32'(bus.dout), 32'h1);
    c1 = last_dv_cyc;
    frame(4'b0110);
    chk("b2b_second", 32'(bus.dout), 32'h6);
    chk("b2b_gap", 32'(last_dv_cyc - c1), 32'd4);

    // Stall of two idle cycles inside a frame
    step(1, 1, 1);
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 0, 1);
    chk("stall_no_dv", 32'(bus.dout_valid), 32'h0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("stall_dout", 32'(bus.dout), 32'hf);

    // Early sync at slot 2 restarts the frame
    step(1, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    chk("early_sync_err", 32'(bus.sync_err), 32'h1);
    chk("early_locked",   32'(bus.locked),   32'h1);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("early_no_dv", 32'(bus.dout_valid), 32'h0);
    step(1, 1, 0);
    chk("early_dout", 32'(bus.dout), 32'hc);

    // Missing sync at slot 0 drops lock
    step(1, 1, 0);
    chk("miss_sync_err", 32'(bus.sync_err), 32'h1);
    chk("miss_locked",   32'(bus.locked),   32'h0);

    // Async reset after lane 2 of a partial frame
    step(0, 1, 1);
    step(1, 1, 0);
    step(0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_dout",   32'(bus.dout),   32'h0);
    chk("arst_slot",   32'(bus.slot),   32'h0);
    chk("arst_locked", 32'(bus.locked), 32'h0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    frame(4'b1010);
    chk("post_rst_dout", 32'(bus.dout), 32'ha);

    // Random stream, mostly well-formed, with occasional sync faults
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (m_next == 0);
      if ($urandom_range(0, 11) == 0) s = ~s;
      d = 1'($urandom_range(0, 1));
      step(d, v, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
